// File: rtl/r900_rs_pkg.sv
// Shared constants, FSM state type and GF(32) helpers for the RS(31) syndrome block.
package r900_rs_pkg;
    localparam int SYM_W   = 5;
    localparam int N_SYM   = 21;
    localparam int N_ROOT  = 5;
    localparam int GAP_LEN = 10;
    localparam int HI_LEN  = 16;
    localparam int LO_LEN  = 5;
    localparam logic [5:0] PRIM_POLY = 6'h25;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HI,
        ST_GAP,
        ST_LO
    } state_t;

    // Multiply by alpha: shift left and reduce by x^5 = x^2 + 1.
    function automatic logic [SYM_W-1:0] gf_xtime(input logic [SYM_W-1:0] x);
        logic [SYM_W-1:0] r;
        r = {x[SYM_W-2:0], 1'b0};
        if (x[SYM_W-1]) r = r ^ PRIM_POLY[SYM_W-1:0];
        return r;
    endfunction

    function automatic logic [SYM_W-1:0] gf_cmul(input logic [SYM_W-1:0] x, input int e);
        logic [SYM_W-1:0] r;
        r = x;
        for (int i = 0; i < 31; i++) begin
            if (i < e) r = gf_xtime(r);
        end
        return r;
    endfunction
endpackage

// File: rtl/r900_rs_synd_gf32_cmul.sv
// Combinational GF(32) multiply by the constant alpha^EXP.
module gf32_cmul
    import r900_rs_pkg::*;
#(
    parameter int EXP = 1
) (
    input  logic [SYM_W-1:0] x,
    output logic [SYM_W-1:0] y
);
    assign y = gf_cmul(x, EXP);
endmodule

// File: rtl/r900_rs_synd.sv
// Shortened RS(31) syndrome generator: Horner evaluation at a^2..a^-2 with a
// 10-cycle zero-fill gap for the implicit positions 14..5.
module r900_rs_synd
    import r900_rs_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sym_vld,
    input  logic                     sym_first,
    input  logic [SYM_W-1:0]         sym_dta,
    output logic                     sym_rdy,
    output logic                     vld_out,
    output logic [N_SYM*SYM_W-1:0]   dta_out,
    output logic [N_ROOT*SYM_W-1:0]  synd_out,
    output logic [7:0]               abort_cnt
);
    state_t state, next_state;
    logic [4:0] cnt, next_cnt;
    logic [N_ROOT-1:0][SYM_W-1:0] s, p;
    logic [N_SYM*SYM_W-1:0] dta;
    logic acc, start, step, last, abort;
    logic [SYM_W-1:0] din;

    // s[4] holds root a^2 down to s[0] for a^-2, matching the synd_out packing.
    gf32_cmul #(.EXP(2))  u_mul_p2 (.x(s[4]), .y(p[4]));
    gf32_cmul #(.EXP(1))  u_mul_p1 (.x(s[3]), .y(p[3]));
    gf32_cmul #(.EXP(30)) u_mul_m1 (.x(s[1]), .y(p[1]));
    gf32_cmul #(.EXP(29)) u_mul_m2 (.x(s[0]), .y(p[0]));
    assign p[2] = s[2];

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        sym_rdy    = (state != ST_GAP);
        acc        = sym_vld && sym_rdy;
        start      = acc && sym_first;
        step       = 1'b0;
        last       = 1'b0;
        din        = sym_dta;
        abort      = start && (state == ST_HI || state == ST_LO);
        if (start) begin
            next_state = ST_HI;
            next_cnt   = 5'(HI_LEN - 1);
        end else begin
            case (state)
                ST_HI: if (acc) begin
                    step     = 1'b1;
                    next_cnt = cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        next_state = ST_GAP;
                        next_cnt   = 5'(GAP_LEN);
                    end
                end
                ST_GAP: begin
                    step     = 1'b1;
                    din      = '0;
                    next_cnt = cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        next_state = ST_LO;
                        next_cnt   = 5'(LO_LEN);
                    end
                end
                ST_LO: if (acc) begin
                    step     = 1'b1;
                    next_cnt = cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        next_state = ST_IDLE;
                        last       = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            s         <= '0;
            dta       <= '0;
            vld_out   <= 1'b0;
            dta_out   <= '0;
            synd_out  <= '0;
            abort_cnt <= '0;
        end else begin
            cnt     <= next_cnt;
            vld_out <= last;
            if (start) begin
                s   <= {N_ROOT{sym_dta}};
                dta <= {{(N_SYM-1)*SYM_W{1'b0}}, sym_dta};
            end else if (step) begin
                s <= p ^ {N_ROOT{din}};
                if (state != ST_GAP) dta <= {dta[(N_SYM-1)*SYM_W-1:0], din};
            end
            // Final results are captured straight from the pos-0 update path.
            if (last) begin
                dta_out  <= {dta[(N_SYM-1)*SYM_W-1:0], sym_dta};
                synd_out <= p ^ {N_ROOT{sym_dta}};
            end
            if (abort && abort_cnt != 8'hFF) abort_cnt <= abort_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_r900_rs_synd.sv
// Self-checking bench for r900_rs_synd: fixed vectors, corner sequences and a
// random stream checked against a log/antilog GF(32) syndrome model.
module tb_r900_rs_synd;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sym_vld = 1'b0;
    logic         sym_first = 1'b0;
    logic [4:0]   sym_dta = '0;
    logic         sym_rdy;
    logic         vld_out;
    logic [104:0] dta_out;
    logic [24:0]  synd_out;
    logic [7:0]   abort_cnt;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int vld_cnt = 0;
    int rdy_low = 0;
    int vld_cyc[$];
    logic [129:0] exp_q[$];
    int alog[31];
    int lg[32];

    typedef struct packed {
        logic [104:0] cw;
        logic [24:0]  synd;
    } vec_t;

    r900_rs_synd dut (
        .clk(clk), .rst(rst), .sym_vld(sym_vld), .sym_first(sym_first),
        .sym_dta(sym_dta), .sym_rdy(sym_rdy), .vld_out(vld_out),
        .dta_out(dta_out), .synd_out(synd_out), .abort_cnt(abort_cnt)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [129:0] got, input logic [129:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, expv);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void build_tables();
        int v;
        v = 1;
        lg[0] = 0;
        for (int i = 0; i < 31; i++) begin
            alog[i] = v;
            lg[v] = i;
            v = v << 1;
            if (v >= 32) v = v ^ 'h25;
        end
    endfunction

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return alog[(lg[a] + lg[b]) % 31];
    endfunction

    function automatic int pos_of(input int i);
        return (i < 16) ? 30 - i : 20 - i;
    endfunction

    function automatic logic [24:0] model_synd(input logic [104:0] cw);
        logic [24:0] r;
        int c, p, j, e, acc;
        r = '0;
        for (int f = 0; f < 5; f++) begin
            j = f - 2;
            acc = 0;
            for (int i = 0; i < 21; i++) begin
                c = int'(cw[(20-i)*5 +: 5]);
                p = pos_of(i);
                e = ((j * p) % 31 + 31) % 31;
                acc = acc ^ gmul(c, alog[e]);
            end
            r[f*5 +: 5] = 5'(acc);
        end
        return r;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        cyc++;
        if (!sym_rdy) rdy_low++;
        if (vld_out) begin
            vld_cnt++;
            vld_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_vld: got vld_out=1 expected no output, synd=%h", synd_out);
            end else begin
                check("codeword", {dta_out, synd_out}, exp_q.pop_front());
            end
        end
    end

    // ---------------- drivers ----------------
    // Called at a negedge; returns at the negedge after the symbol is taken.
    task automatic drive_sym(input logic [4:0] d, input bit first, input int idle_max);
        int guard;
        repeat ($urandom_range(0, idle_max)) begin
            sym_vld = 1'b0;
            sym_first = 1'($urandom_range(0, 1));
            sym_dta = 5'($urandom);
            @(negedge clk);
        end
        sym_vld = 1'b1;
        sym_first = first;
        sym_dta = d;
        guard = 0;
        while (!sym_rdy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            total++;
            bad++;
            $display("FAIL rdy_timeout: sym_rdy stuck low for %0d cycles, required <= 10", guard);
        end
        @(negedge clk);
        sym_vld = 1'b0;
        sym_first = 1'b0;
    endtask

    task automatic send_part(input logic [104:0] cw, input int n, input int idle_max);
        for (int i = 0; i < n; i++) drive_sym(cw[(20-i)*5 +: 5], i == 0, idle_max);
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("drain", 130'(exp_q.size()), 130'd0);
    endtask

    function automatic logic [104:0] rand_cw();
        logic [104:0] r;
        for (int i = 0; i < 21; i++) r[i*5 +: 5] = 5'($urandom);
        return r;
    endfunction

    // ---------------- test sequence ----------------
    initial begin : main
        vec_t vecs[5];
        logic [104:0] cw;
        int v0, r0, n0;

        build_tables();
        vecs[0] = '{cw: '0,            synd: 25'h0};
        vecs[1] = '{cw: 105'h1,        synd: 25'h108421};
        vecs[2] = '{cw: 105'h1 << 25,  synd: {5'd18, 5'd31, 5'd1, 5'd27, 5'd2}};
        vecs[3] = '{cw: 105'h1 << 100, synd: {5'd9, 5'd18, 5'd1, 5'd2, 5'd4}};
        vecs[4] = '{cw: 105'h1 << 20,  synd: {5'd13, 5'd16, 5'd1, 5'd11, 5'd15}};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_rdy",   130'(sym_rdy),   130'd1);
        check("rst_vld",   130'(vld_out),   130'd0);
        check("rst_dta",   130'(dta_out),   130'd0);
        check("rst_synd",  130'(synd_out),  130'd0);
        check("rst_abort", 130'(abort_cnt), 130'd0);

        // Known vectors, including idle-state junk that must be dropped.
        for (int k = 0; k < 5; k++) begin
            sym_vld = 1'b1; sym_first = 1'b0; sym_dta = 5'h1F;
            @(negedge clk);
            sym_vld = 1'b0;
            exp_q.push_back({vecs[k].cw, vecs[k].synd});
            send_part(vecs[k].cw, 21, 0);
        end
        wait_drain();

        // Restart after 8 HI symbols.
        v0 = vld_cnt;
        r0 = rdy_low;
        send_part(rand_cw(), 8, 1);
        cw = rand_cw();
        exp_q.push_back({cw, model_synd(cw)});
        send_part(cw, 21, 0);
        wait_drain();
        check("abort_cnt", 130'(abort_cnt), 130'd1);
        check("abort_vld_count", 130'(vld_cnt - v0), 130'd1);
        check("gap_rdy_low", 130'(rdy_low - r0), 130'd10);

        // Back-to-back with sym_vld held high.
        n0 = vld_cyc.size();
        for (int k = 0; k < 3; k++) begin
            cw = rand_cw();
            exp_q.push_back({cw, model_synd(cw)});
            send_part(cw, 21, 0);
        end
        wait_drain();
        check("b2b_count", 130'(vld_cyc.size() - n0), 130'd3);
        if (vld_cyc.size() - n0 == 3) begin
            check("b2b_period0", 130'(vld_cyc[n0+1] - vld_cyc[n0]), 130'd31);
            check("b2b_period1", 130'(vld_cyc[n0+2] - vld_cyc[n0+1]), 130'd31);
        end

        // Random stream with random valid gaps and stalls.
        for (int k = 0; k < 20; k++) begin
            cw = rand_cw();
            exp_q.push_back({cw, model_synd(cw)});
            send_part(cw, 21, 3);
        end
        wait_drain();

        // Reset while in LO discards the partial codeword.
        v0 = vld_cnt;
        send_part(rand_cw(), 18, 0);
        do_reset();
        check("lo_rst_dta",   130'(dta_out),   130'd0);
        check("lo_rst_synd",  130'(synd_out),  130'd0);
        check("lo_rst_abort", 130'(abort_cnt), 130'd0);
        check("lo_rst_rdy",   130'(sym_rdy),   130'd1);
        repeat (5) @(negedge clk);
        check("lo_rst_no_vld", 130'(vld_cnt - v0), 130'd0);
        cw = rand_cw();
        exp_q.push_back({cw, model_synd(cw)});
        send_part(cw, 21, 1);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
